alu_share_arbiter: RTL and testbench

Shares a single ALU between two requesters: the integer execute path (requester 0) and the branch/address unit (requester 1). It uses round-robin arbitration and valid/ready handshakes. Each operation's operands are latched, the ALU evaluates them in a registered execute cycle, and the result is held until the owning requester accepts it. Only one operation is in flight at a time.

---
 rtl/alu_share_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU between the execute path (req 0)
// and the branch/address unit (req 1); one operation in flight, result held until taken.
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    input  logic [DATA_WIDTH-1:0]    req0_a,
    input  logic [DATA_WIDTH-1:0]    req0_b,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    input  logic [DATA_WIDTH-1:0]    req1_a,
    input  logic [DATA_WIDTH-1:0]    req1_b,
    output logic                     resp0_valid,
    input  logic                     resp0_ready,
    output logic                     resp1_valid,
    input  logic                     resp1_ready,
    output logic [DATA_WIDTH-1:0]    resp_result,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(0);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(1);
    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(2);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(3);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(5);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(6);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(7);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(8);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(9);

    state_t                   state_q;
    logic                     ptr_q;
    logic                     owner_q;
    logic [OPCODE_LENGTH-1:0] op_q;
    logic [DATA_WIDTH-1:0]    a_q;
    logic [DATA_WIDTH-1:0]    b_q;
    logic [DATA_WIDTH-1:0]    result_q;
    logic [DATA_WIDTH-1:0]    result_d;
    logic                     resp0_valid_q;
    logic                     resp1_valid_q;
    logic                     busy_q;

    logic                     grant_any;
    logic                     grant_id;
    logic                     resp_ack;
    logic [4:0]               shamt;

    // Grant is combinational from state, pointer and valids only; gated by rst_n
    // so no ready escapes while reset is held.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (rst_n && state_q == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ptr_q;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any &&  grant_id;

    assign shamt = b_q[4:0];

    always_comb begin
        result_d = '0;
        case (op_q)
            OP_ADD:  result_d = a_q + b_q;
            OP_SUB:  result_d = a_q - b_q;
            OP_AND:  result_d = a_q & b_q;
            OP_OR:   result_d = a_q | b_q;
            OP_XOR:  result_d = a_q ^ b_q;
            OP_SLL:  result_d = a_q << shamt;
            OP_SRL:  result_d = a_q >> shamt;
            OP_SRA:  result_d = $signed(a_q) >>> shamt;
            OP_EQ:   result_d = {{(DATA_WIDTH-1){1'b0}}, (a_q == b_q)};
            OP_SLT:  result_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: result_d = '0;
        endcase
    end

    assign resp_ack = owner_q ? resp1_ready : resp0_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: operand and result registers are reset too, so no stale data is visible
    // on resp_result after an aborted operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= 1'b0;
            owner_q       <= 1'b0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            result_q      <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        owner_q <= grant_id;
                        ptr_q   <= ~grant_id;
                        op_q    <= grant_id ? req1_op : req0_op;
                        a_q     <= grant_id ? req1_a  : req0_a;
                        b_q     <= grant_id ? req1_b  : req0_b;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q      <= result_d;
                    resp0_valid_q <= ~owner_q;
                    resp1_valid_q <= owner_q;
                    state_q       <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ack) begin
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign resp_result = result_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: grants push expected results from a
// reference ALU model, response handshakes pop and compare them.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp_result;
    logic        busy;

    typedef struct packed {
        logic        owner;
        logic [31:0] result;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          accept_cyc = -100;
    logic        exp_ptr  = 1'b0;
    logic        prev_valid = 1'b0;
    logic        hs_prev  = 1'b0;
    logic [31:0] prev_result = '0;

    alu_share_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp0_valid(resp0_valid),
        .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid),
        .resp1_ready(resp1_ready),
        .resp_result(resp_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [4:0]  s;
        logic [31:0] fill;
        s = b[4:0];
        fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a + ~b + 32'd1;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << s;
            4'd6:    return a >> s;
            4'd7:    return (a >> s) | fill;
            4'd8:    return (a == b) ? 32'd1 : 32'd0;
            4'd9:    return ((a[31] && !b[31]) || ((a[31] == b[31]) && (a < b))) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Monitor: model the pointer, push on grant, pop on response handshake.
    always @(negedge clk) begin
        exp_t e;
        logic g;
        logic cur_valid;
        cyc++;
        if (!rst_n) begin
            sb_q.delete();
            exp_ptr    = 1'b0;
            prev_valid = 1'b0;
            hs_prev    = 1'b0;
            accept_cyc = -100;
        end else begin
            if (hs_prev)
                check("idle_after_hs", {busy, resp0_valid, resp1_valid}, 0);
            hs_prev = 1'b0;
            if (busy)
                check("no_ready_busy", {req0_ready, req1_ready}, 0);
            if (cyc == accept_cyc + 1)
                check("busy_after_accept", busy, 1);
            if (req0_ready || req1_ready) begin
                check("ready_onehot", req0_ready & req1_ready, 0);
                g = req1_ready;
                if (req0_valid && req1_valid)
                    check("rr_grant", g, exp_ptr);
                exp_ptr  = ~g;
                e.owner  = g;
                e.result = g ? alu_model(req1_op, req1_a, req1_b)
                             : alu_model(req0_op, req0_a, req0_b);
                sb_q.push_back(e);
                accept_cyc = cyc;
            end
            cur_valid = resp0_valid | resp1_valid;
            if (cur_valid) begin
                check("resp_onehot", resp0_valid & resp1_valid, 0);
                if (!prev_valid)
                    check("resp_latency", 64'(cyc - accept_cyc), 2);
                else
                    check("resp_stable", resp_result, prev_result);
                if (resp1_valid ? resp1_ready : resp0_ready) begin
                    hs_prev = 1'b1;
                    if (sb_q.size() == 0) begin
                        check("spurious_resp", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("resp_owner", resp1_valid, e.owner);
                        check("resp_result_sb", resp_result, e.result);
                    end
                end
            end
            prev_valid  = cur_valid;
            prev_result = resp_result;
        end
    end

    // All driver tasks start and end aligned 1 time unit after a rising edge.
    task automatic issue(input logic id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        bit done = 0;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) done = 1;
        end
        if (!done) check("issue_timeout", 0, 1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_resp(input logic id, input string tag, input logic [31:0] exp);
        bit done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (id ? resp1_valid : resp0_valid) begin
                done = 1;
                check(tag, resp_result, exp);
                check("other_resp_low", id ? resp0_valid : resp1_valid, 0);
            end
        end
        if (!done) check("resp_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic id, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag, input logic [31:0] exp);
        issue(id, op, a, b);
        wait_resp(id, tag, exp);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0) done = 1;
        end
        if (!done) check("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_op = '0; req1_op = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;

        // Reset values, with a request pending to prove ready is suppressed
        req0_valid = 1'b1;
        #2;
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_resp_valid", {resp0_valid, resp1_valid}, 0);
        check("rst_result", resp_result, 0);
        check("rst_busy", busy, 0);
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle with no requests
        repeat (4) begin
            @(negedge clk);
            check("idle_ready", {req0_ready, req1_ready}, 0);
            check("idle_busy", busy, 0);
        end
        @(posedge clk); #1;

        // Single ADD with carry wrap, then a few more operations
        run_op(0, 4'b0000, 32'hFFFF_FFFF, 32'd2, "add_wrap", 32'h0000_0001);
        run_op(1, 4'b0100, 32'hF0F0_1234, 32'h0FF0_FFFF, "xor", 32'hFF00_EDCB);
        run_op(0, 4'b0101, 32'h0000_0003, 32'hFFFF_FFE4, "sll_mask", 32'h0000_0030);
        run_op(1, 4'b0110, 32'h8000_0000, 32'd31, "srl", 32'h0000_0001);

        // Contention from reset: grants must alternate starting with requester 0
        do_reset();
        req0_op = 4'b0000; req0_a = 32'd10; req0_b = 32'd20;
        req1_op = 4'b0001; req1_a = 32'd3;  req1_b = 32'd5;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        run_op(1, 4'b0001, 32'd3, 32'd5, "sub_wrap", 32'hFFFF_FFFE);

        // Backpressure on requester 1 while requester 0 waits
        resp1_ready = 1'b0;
        issue(1, 4'b0111, 32'h8000_0000, 32'h0000_0024);
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (resp1_valid) seen = 1;
            end
            if (!seen) check("bp_resp_timeout", 0, 1);
        end
        req0_valid = 1'b1; req0_op = 4'b1000; req0_a = 32'h1234; req0_b = 32'h1234;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", resp1_valid, 1);
            check("bp_result", resp_result, 32'hF800_0000);
            check("bp_busy", busy, 1);
            check("bp_no_ready", {req0_ready, req1_ready}, 0);
        end
        @(posedge clk); #1 resp1_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_back_idle_ready", req0_ready, 1);
        check("bp_back_idle_valid", resp1_valid, 0);
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_resp(0, "eq", 32'd1);

        // Compare and undefined codes
        run_op(0, 4'b1001, 32'hFFFF_FFFF, 32'd1, "slt_signed", 32'd1);
        run_op(1, 4'b1001, 32'd1, 32'hFFFF_FFFF, "slt_false", 32'd0);
        run_op(0, 4'b1000, 32'h1234, 32'h1235, "eq_false", 32'd0);
        run_op(0, 4'b0011, 32'h00FF_0000, 32'h0000_00FF, "or", 32'h00FF_00FF);
        run_op(1, 4'b1100, 32'hDEAD_BEEF, 32'h1234_5678, "undef_op", 32'd0);

        // Reset in the middle of EXEC discards the operation
        run_op(0, 4'b0010, 32'hFFFF_0000, 32'h0F0F_0F0F, "and", 32'h0F0F_0000);
        issue(0, 4'b0000, 32'd1, 32'd2);
        req1_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midexec_rst_ready", {req0_ready, req1_ready}, 0);
        check("midexec_rst_valid", {resp0_valid, resp1_valid}, 0);
        check("midexec_rst_result", resp_result, 0);
        check("midexec_rst_busy", busy, 0);
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("no_resp_after_rst", {resp0_valid, resp1_valid, busy}, 0);
        end
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
